// File: rtl/light_phase_scheduler.sv
// Dwell timer and step sequencer for the main/side-street light state machine.
// Times each phase in tick_in units, strobes step, and latches pedestrian requests.
module light_phase_scheduler #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned GREEN_TICKS  = 50,
  parameter int unsigned YELLOW_TICKS = 10,
  parameter int unsigned ALLRED_TICKS = 5,
  parameter int unsigned PED_TICKS    = 30,
  parameter int unsigned ACK_TIMEOUT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [2:0]       phase,
  input  logic             hold,
  input  logic             ped_btn,
  output logic             step,
  output logic             ped_req,
  output logic [CNT_W-1:0] remaining,
  output logic             fault
);

  localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0] PhPed     = 3'd6;
  localparam logic [2:0] PhInvalid = 3'd7;

  typedef enum logic [1:0] {StLoad, StCount, StAck, StFault} state_e;

  state_e          state_q;
  logic [2:0]      phase_q;
  logic [AckW-1:0] wait_q;
  logic            sync1_q, sync2_q, sync3_q;
  logic            ped_edge;

  function automatic logic [CNT_W-1:0] dwell(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd3: dwell = CNT_W'(GREEN_TICKS);
      3'd1, 3'd4: dwell = CNT_W'(YELLOW_TICKS);
      3'd2, 3'd5: dwell = CNT_W'(ALLRED_TICKS);
      3'd6:       dwell = CNT_W'(PED_TICKS);
      default:    dwell = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StLoad;
      phase_q   <= 3'd0;
      wait_q    <= '0;
      step      <= 1'b0;
      remaining <= '0;
      fault     <= 1'b0;
    end else if (phase == PhInvalid) begin
      state_q   <= StFault;
      fault     <= 1'b1;
      step      <= 1'b0;
      remaining <= '0;
    end else begin
      step <= 1'b0;
      unique case (state_q)
        StLoad: begin
          remaining <= dwell(phase);
          phase_q   <= phase;
          state_q   <= StCount;
        end
        StCount: begin
          // External phase change restarts timing without issuing a step.
          if (phase != phase_q) begin
            state_q <= StLoad;
          end else if (tick_in && !hold && remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              step    <= 1'b1;
              wait_q  <= '0;
              state_q <= StAck;
            end
          end
        end
        StAck: begin
          if (phase != phase_q) begin
            state_q <= StLoad;
          end else if (wait_q == AckW'(ACK_TIMEOUT - 1)) begin
            fault   <= 1'b1;
            state_q <= StFault;
          end else begin
            wait_q <= wait_q + AckW'(1);
          end
        end
        StFault: begin
          remaining <= '0;
        end
        default: state_q <= StFault;
      endcase
    end
  end

  assign ped_edge = sync2_q & ~sync3_q;

  // Clear during PED wins over a coincident press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      ped_req <= 1'b0;
    end else begin
      sync1_q <= ped_btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (phase == PhPed) begin
        ped_req <= 1'b0;
      end else if (ped_edge) begin
        ped_req <= 1'b1;
      end
    end
  end

endmodule
